// File: rtl/audio_echo_pipe_if.sv
// Codec-side read/write handshake bundle for audio_echo_pipe.
// master = processing stage (pops input pairs, pushes output pairs); slave = codec.
interface audio_echo_pipe_if #(
  parameter int unsigned DATA_W = 24
);
  logic              read_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              read;
  logic              write_ready;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;
  logic              write;

  modport master (
    input  read_ready, readdata_left, readdata_right, write_ready,
    output read, writedata_left, writedata_right, write
  );

  modport slave (
    output read_ready, readdata_left, readdata_right, write_ready,
    input  read, writedata_left, writedata_right, write
  );
endinterface

// File: rtl/audio_echo_pipe.sv
// Stereo echo/delay stage between codec read and write handshakes.
// Per-channel circular delay line in synchronous RAM; one sample pair in flight.
module audio_echo_pipe #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned GAIN_SHIFT = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [DEPTH_LOG2-1:0] delay_len,
  output logic                  busy,
  audio_echo_pipe_if.master     codec
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [DEPTH_LOG2-1:0]    ptr_t;
  typedef enum logic [2:0] {StClear, StIdle, StRdMem, StCompute, StWaitWr} state_e;

  state_e  state_q, state_d;
  ptr_t    clr_ptr_q, clr_ptr_d;
  ptr_t    wr_ptr_q, wr_ptr_d;
  ptr_t    delay_q, delay_d;
  logic [1:0] mode_q, mode_d;
  sample_t x_l_q, x_l_d, x_r_q, x_r_d;
  sample_t y_l_q, y_l_d, y_r_q, y_r_d;

  sample_t mem_l [Depth];
  sample_t mem_r [Depth];
  sample_t d_l_q, d_r_q;
  logic    mem_we;
  ptr_t    mem_waddr;
  sample_t mem_wdata_l, mem_wdata_r;
  ptr_t    rd_addr;
  logic    rd_en;
  sample_t y_cmp_l, y_cmp_r;

  // Saturate to the sample range after a one-bit-wider add.
  function automatic sample_t sat_add(sample_t a, sample_t b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) begin
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return s[DATA_W-1:0];
  endfunction

  // delay_len=0 lands on wr_ptr itself, i.e. the oldest entry.
  assign rd_addr = wr_ptr_q - delay_q;
  assign rd_en   = (state_q == StRdMem);

  always_comb begin
    sample_t e_l, e_r;
    e_l = d_l_q >>> GAIN_SHIFT;
    e_r = d_r_q >>> GAIN_SHIFT;
    unique case (mode_q)
      2'b00: begin
        y_cmp_l = x_l_q;
        y_cmp_r = x_r_q;
      end
      2'b11: begin
        y_cmp_l = d_l_q;
        y_cmp_r = d_r_q;
      end
      default: begin
        y_cmp_l = sat_add(x_l_q, e_l);
        y_cmp_r = sat_add(x_r_q, e_r);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    delay_d     = delay_q;
    mode_d      = mode_q;
    x_l_d       = x_l_q;
    x_r_d       = x_r_q;
    y_l_d       = y_l_q;
    y_r_d       = y_r_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    mem_wdata_l = x_l_q;
    mem_wdata_r = x_r_q;
    codec.read  = 1'b0;
    codec.write = 1'b0;

    unique case (state_q)
      StClear: begin
        mem_we      = !reset;
        mem_waddr   = clr_ptr_q;
        mem_wdata_l = '0;
        mem_wdata_r = '0;
        clr_ptr_d   = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = StIdle;
      end
      StIdle: begin
        if (codec.read_ready && !reset) begin
          codec.read = 1'b1;
          x_l_d      = codec.readdata_left;
          x_r_d      = codec.readdata_right;
          mode_d     = mode;
          delay_d    = delay_len;
          state_d    = StRdMem;
        end
      end
      StRdMem: state_d = StCompute;
      StCompute: begin
        y_l_d   = y_cmp_l;
        y_r_d   = y_cmp_r;
        state_d = StWaitWr;
      end
      StWaitWr: begin
        if (codec.write_ready && !reset) begin
          codec.write = 1'b1;
          mem_we      = 1'b1;
          // Feedback mode recirculates the output; all others store the dry input.
          mem_wdata_l = (mode_q == 2'b10) ? y_l_q : x_l_q;
          mem_wdata_r = (mode_q == 2'b10) ? y_r_q : x_r_q;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StClear;
    endcase
  end

  assign busy                  = reset || (state_q == StClear);
  assign codec.writedata_left  = y_l_q;
  assign codec.writedata_right = y_r_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      wr_ptr_q  <= '0;
      delay_q   <= '0;
      mode_q    <= 2'b00;
      x_l_q     <= '0;
      x_r_q     <= '0;
      y_l_q     <= '0;
      y_r_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      delay_q   <= delay_d;
      mode_q    <= mode_d;
      x_l_q     <= x_l_d;
      x_r_q     <= x_r_d;
      y_l_q     <= y_l_d;
      y_r_q     <= y_r_d;
    end
  end

  // Delay-line RAM: no reset, contents initialised by the clear sweep.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) begin
      mem_l[mem_waddr] <= mem_wdata_l;
      mem_r[mem_waddr] <= mem_wdata_r;
    end
    if (rd_en) begin
      d_l_q <= mem_l[rd_addr];
      d_r_q <= mem_r[rd_addr];
    end
  end

endmodule

// File: tb/tb_audio_echo_pipe.sv
// Randomised self-checking bench for audio_echo_pipe against a sample-history model.
module tb_audio_echo_pipe;
  localparam int unsigned DataW     = 24;
  localparam int unsigned DepthLog2 = 4;
  localparam int unsigned GainShift = 1;
  localparam int          Depth     = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [3:0] delay_len;
  logic       busy;
  int         vectors;
  int         miscompares;

  // Model: everything stored into the delay line since the last clear, oldest first.
  logic [23:0] hist_l[$];
  logic [23:0] hist_r[$];

  audio_echo_pipe_if #(.DATA_W(DataW)) bus ();

  audio_echo_pipe #(
    .DATA_W    (DataW),
    .DEPTH_LOG2(DepthLog2),
    .GAIN_SHIFT(GainShift)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .mode     (mode),
    .delay_len(delay_len),
    .busy     (busy),
    .codec    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_out(input logic [1:0] m, input logic [23:0] x,
                                          input logic [23:0] d);
    longint xs, ds, s;
    xs = longint'($signed(x));
    ds = longint'($signed(d));
    s  = xs + (ds >>> GainShift);
    if (s > 64'sd8388607) s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    case (m)
      2'b00:   return x;
      2'b11:   return d;
      default: return s[23:0];
    endcase
  endfunction

  task automatic model_step(input logic [1:0] m, input logic [3:0] dl, input logic [23:0] xl,
                            input logic [23:0] xr, output logic [23:0] yl,
                            output logic [23:0] yr);
    int n, dn;
    logic [23:0] dlv, drv;
    n   = hist_l.size();
    dn  = (dl == 4'd0) ? Depth : int'(dl);
    dlv = (n >= dn) ? hist_l[n-dn] : 24'h0;
    drv = (n >= dn) ? hist_r[n-dn] : 24'h0;
    yl  = ref_out(m, xl, dlv);
    yr  = ref_out(m, xr, drv);
    hist_l.push_back((m == 2'b10) ? yl : xl);
    hist_r.push_back((m == 2'b10) ? yr : xr);
  endtask

  // Drives one pair through the DUT; write_ready is withheld for `stall` extra cycles.
  task automatic xfer(input logic [1:0] m, input logic [3:0] dl, input logic [23:0] il,
                      input logic [23:0] ir, input int stall, output logic [23:0] ol,
                      output logic [23:0] orr, output int lat, output bit tmo,
                      output bit stray);
    int cyc;
    tmo = 1'b0; stray = 1'b0; lat = 0; ol = '0; orr = '0;
    @(negedge clk);
    mode = m; delay_len = dl;
    bus.readdata_left = il; bus.readdata_right = ir;
    bus.read_ready = 1'b1; bus.write_ready = 1'b0;
    cyc = 0;
    #1;
    while (!bus.read) begin
      cyc++;
      if (cyc > 200) begin tmo = 1'b1; bus.read_ready = 1'b0; return; end
      @(negedge clk); #1;
    end
    // Scramble inputs after the pop; read_ready stays high to expose a stray read.
    @(negedge clk);
    bus.readdata_left = 24'($urandom); bus.readdata_right = 24'($urandom);
    mode = 2'($urandom); delay_len = 4'($urandom);
    lat = 1;
    forever begin
      bus.write_ready = (lat >= 3 + stall);
      #1;
      if (bus.read) stray = 1'b1;
      if (bus.write) break;
      lat++;
      if (lat > 200) begin tmo = 1'b1; bus.read_ready = 1'b0; return; end
      @(negedge clk);
    end
    ol = bus.writedata_left; orr = bus.writedata_right;
    bus.read_ready = 1'b0;
  endtask

  task automatic apply_reset();
    int cnt;
    @(negedge clk);
    reset = 1'b1; bus.read_ready = 1'b0; bus.write_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    hist_l.delete(); hist_r.delete();
    cnt = 0;
    #1;
    while (busy && cnt < 100) begin cnt++; @(negedge clk); #1; end
    if (busy) begin
      vectors++; miscompares++;
      $display("FAIL reset_clear_timeout: busy=%0b after %0d cycles, want 0", busy, cnt);
    end
  endtask

  task automatic test_reset();
    int cnt;
    bit rd_seen;
    @(negedge clk);
    reset = 1'b1; bus.read_ready = 1'b1; bus.write_ready = 1'b1;
    mode = 2'b00; delay_len = 4'd0;
    bus.readdata_left = 24'h0; bus.readdata_right = 24'h0;
    @(negedge clk); #1;
    vectors++; if (bus.read !== 1'b0) begin miscompares++;
      $display("FAIL reset_read: got %b want 0", bus.read); end
    vectors++; if (bus.write !== 1'b0) begin miscompares++;
      $display("FAIL reset_write: got %b want 0", bus.write); end
    vectors++; if (bus.writedata_left !== 24'h0 || bus.writedata_right !== 24'h0) begin
      miscompares++; $display("FAIL reset_writedata: got %h/%h want 0/0",
                              bus.writedata_left, bus.writedata_right); end
    vectors++; if (busy !== 1'b1) begin miscompares++;
      $display("FAIL reset_busy: got %b want 1", busy); end
    @(negedge clk);
    reset = 1'b0;
    hist_l.delete(); hist_r.delete();
    cnt = 0; rd_seen = 1'b0;
    #1;
    while (busy === 1'b1 && cnt < 100) begin
      if (bus.read !== 1'b0) rd_seen = 1'b1;
      cnt++;
      @(negedge clk); #1;
    end
    vectors++; if (cnt != Depth) begin miscompares++;
      $display("FAIL clear_cycles: got %0d want %0d", cnt, Depth); end
    vectors++; if (rd_seen) begin miscompares++;
      $display("FAIL clear_read_low: read seen high=%b want 0", rd_seen); end
    vectors++; if (bus.read !== 1'b1) begin miscompares++;
      $display("FAIL first_idle_read: got %b want 1", bus.read); end
    bus.read_ready = 1'b0;
  endtask

  task automatic test_bypass();
    logic [23:0] ol, orr, el, er;
    int lat; bit tmo, stray;
    model_step(2'b00, 4'd0, 24'h123456, 24'hFEDCBA, el, er);
    xfer(2'b00, 4'd0, 24'h123456, 24'hFEDCBA, 0, ol, orr, lat, tmo, stray);
    vectors++; if (tmo || lat != 3) begin miscompares++;
      $display("FAIL bypass_latency: got %0d (timeout=%b) want 3", lat, tmo); end
    vectors++; if (ol !== el || orr !== er) begin miscompares++;
      $display("FAIL bypass_data: got %h/%h want %h/%h", ol, orr, el, er); end
    vectors++; if (stray) begin miscompares++;
      $display("FAIL bypass_stray_read: got %b want 0", stray); end
  endtask

  task automatic test_ff_echo();
    logic [23:0] ins [3];
    logic [23:0] ol, orr, el, er;
    int lat; bit tmo, stray;
    ins[0] = 24'h100000; ins[1] = 24'h0; ins[2] = 24'h0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      model_step(2'b01, 4'd2, ins[i], ins[i], el, er);
      xfer(2'b01, 4'd2, ins[i], ins[i], 0, ol, orr, lat, tmo, stray);
      vectors++; if (tmo || ol !== el || orr !== er) begin miscompares++;
        $display("FAIL ff_echo[%0d]: got %h/%h (timeout=%b) want %h/%h",
                 i, ol, orr, tmo, el, er); end
    end
  endtask

  task automatic test_feedback_sat();
    logic [1:0]  ms  [8];
    logic [23:0] ins [8];
    logic [23:0] ol, orr, el, er;
    int lat; bit tmo, stray;
    ms  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    ins = '{24'h100000, 24'h0, 24'h0, 24'h0, 24'h7FFFF0, 24'h7FFFF0, 24'h800010, 24'h800010};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      model_step(ms[i], 4'd1, ins[i], ~ins[i], el, er);
      xfer(ms[i], 4'd1, ins[i], ~ins[i], 0, ol, orr, lat, tmo, stray);
      vectors++; if (tmo || ol !== el || orr !== er) begin miscompares++;
        $display("FAIL feedback_sat[%0d]: got %h/%h (timeout=%b) want %h/%h",
                 i, ol, orr, tmo, el, er); end
    end
  endtask

  task automatic test_pure_delay_wrap();
    logic [23:0] ol, orr, el, er;
    int lat; bit tmo, stray;
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      model_step(2'b11, 4'd0, 24'(k), 24'(k + 100), el, er);
      xfer(2'b11, 4'd0, 24'(k), 24'(k + 100), 0, ol, orr, lat, tmo, stray);
      vectors++; if (tmo || ol !== el || orr !== er) begin miscompares++;
        $display("FAIL pure_delay[%0d]: got %h/%h (timeout=%b) want %h/%h",
                 k, ol, orr, tmo, el, er); end
    end
  endtask

  task automatic test_random();
    logic [23:0] il, ir, ol, orr, el, er;
    logic [1:0] m;
    logic [3:0] dl;
    int lat, stall; bit tmo, stray;
    for (int i = 0; i < 60; i++) begin
      m = 2'($urandom); dl = 4'($urandom);
      il = 24'($urandom); ir = 24'($urandom);
      if (i % 5 == 0) il = {il[23], 3'b111, il[19:0]};
      stall = int'($urandom_range(0, 3));
      model_step(m, dl, il, ir, el, er);
      xfer(m, dl, il, ir, stall, ol, orr, lat, tmo, stray);
      vectors++; if (tmo || ol !== el || orr !== er || lat != 3 + stall || stray) begin
        miscompares++;
        $display("FAIL random[%0d] m=%0d dl=%0d: got %h/%h lat=%0d stray=%b tmo=%b want %h/%h lat=%0d",
                 i, m, dl, ol, orr, lat, stray, tmo, el, er, 3 + stall); end
    end
  endtask

  task automatic test_backpressure_reset();
    logic [23:0] ol, orr, el, er;
    int lat, cnt; bit tmo, stray, bad, wr_seen;
    apply_reset();
    @(negedge clk);
    mode = 2'b00; delay_len = 4'd3;
    bus.readdata_left = 24'hABCDEF; bus.readdata_right = 24'h135790;
    bus.read_ready = 1'b1; bus.write_ready = 1'b0;
    cnt = 0; #1;
    while (!bus.read && cnt < 100) begin cnt++; @(negedge clk); #1; end
    vectors++; if (!bus.read) begin miscompares++;
      $display("FAIL bp_read: got %b want 1", bus.read); end
    @(negedge clk); @(negedge clk); @(negedge clk);
    bus.readdata_left = 24'h111111;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.writedata_left !== 24'hABCDEF ||
          bus.writedata_right !== 24'h135790) bad = 1'b1;
      @(negedge clk);
    end
    vectors++; if (bad) begin miscompares++;
      $display("FAIL bp_hold: got wd=%h/%h read=%b want wd=abcdef/135790 read=0 write=0",
               bus.writedata_left, bus.writedata_right, bus.read); end
    reset = 1'b1; bus.write_ready = 1'b1;
    #1;
    vectors++; if (bus.write !== 1'b0) begin miscompares++;
      $display("FAIL mid_reset_write: got %b want 0", bus.write); end
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b1 || bus.write !== 1'b0) begin miscompares++;
      $display("FAIL mid_reset_busy: got busy=%b write=%b want 1/0", busy, bus.write); end
    @(negedge clk);
    reset = 1'b0; bus.read_ready = 1'b0;
    hist_l.delete(); hist_r.delete();
    cnt = 0; wr_seen = 1'b0; #1;
    while (busy === 1'b1 && cnt < 100) begin
      if (bus.write !== 1'b0) wr_seen = 1'b1;
      cnt++; @(negedge clk); #1;
    end
    vectors++; if (cnt != Depth || wr_seen) begin miscompares++;
      $display("FAIL mid_reset_clear: got %0d cycles write_seen=%b want %0d/0",
               cnt, wr_seen, Depth); end
    model_step(2'b11, 4'd0, 24'h222222, 24'h333333, el, er);
    xfer(2'b11, 4'd0, 24'h222222, 24'h333333, 0, ol, orr, lat, tmo, stray);
    vectors++; if (tmo || ol !== el || orr !== er) begin miscompares++;
      $display("FAIL post_reset_delay: got %h/%h (timeout=%b) want %h/%h",
               ol, orr, tmo, el, er); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; mode = 2'b00; delay_len = 4'd0;
    bus.read_ready = 1'b0; bus.write_ready = 1'b0;
    bus.readdata_left = '0; bus.readdata_right = '0;
    test_reset();
    test_bypass();
    test_ff_echo();
    test_feedback_sat();
    test_pure_delay_wrap();
    test_random();
    test_backpressure_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_echo_pipe.md
# audio_echo_pipe

Parametrised stereo processing stage between the `audio_codec` read and write handshakes, replacing the direct readdata-to-writedata loopback. Each sample pair is pulled from the codec and stored in a per-channel circular delay line held in block RAM. A processed pair (bypass, feed-forward echo, feedback echo or pure delay) is pushed back to the codec. One sample pair is in flight at a time; the handshake pins connect one-to-one to the codec.

## Interface
Parameters:
- `DATA_W`, 24, sample width, signed two's complement.
- `DEPTH_LOG2`, 12, log2 of delay-line depth per channel, in samples.
- `GAIN_SHIFT`, 1, arithmetic right shift applied to the delayed sample (echo gain 2^-GAIN_SHIFT).

Ports:
- `CLOCK_50`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  2  00 bypass, 01 feed-forward echo, 10 feedback echo, 11 pure delay.
- `delay_len`  in  DEPTH_LOG2  delay in samples; 0 means 2^DEPTH_LOG2.
- `read_ready`  in  1  codec has an input sample pair.
- `readdata_left`, `readdata_right`  in  DATA_W  codec input samples, valid while `read_ready`.
- `read`  out  1  one-cycle pop of the codec input pair.
- `write_ready`  in  1  codec can accept an output pair.
- `writedata_left`, `writedata_right`  out  DATA_W  processed samples.
- `write`  out  1  one-cycle push to the codec.
- `busy`  out  1  high during the post-reset memory clear.

## Operation
- **States:** CLEAR, IDLE, RD_MEM, COMPUTE, WAIT_WR.
- **CLEAR:**
  - Entered on reset.
  - Writes zero to both delay lines at address `clr_ptr`, 0 to 2^DEPTH_LOG2-1, one address per cycle.
  - `busy`=1. Moves to IDLE after the last address.
- **IDLE:**
  - `read` = `read_ready` (combinational).
  - When `read_ready`=1: capture `readdata_*` into x_l/x_r, sample `mode` and `delay_len`, go to RD_MEM.
- **RD_MEM:** Present rd_addr = (wr_ptr − delay_len) mod 2^DEPTH_LOG2 to the synchronous RAM (1-cycle read latency).
- **COMPUTE:** With d = RAM output and e = d >>> GAIN_SHIFT (sign-preserving):
  - Mode 00: y = x.
  - Modes 01 and 10: y = sat(x + e).
  - Mode 11: y = d.
  - Register y into `writedata_*`, then go to WAIT_WR.
- **Saturating add:**
  - Computed at DATA_W+1 bits.
  - Clamp to +2^(DATA_W−1)−1 or −2^(DATA_W−1).
  - Left and right channels saturate independently.
- **WAIT_WR:**
  - `write` = `write_ready` (combinational).
  - On `write_ready`=1, in the same cycle:
    - RAM[wr_ptr] ← y in mode 10, x in all other modes.
    - wr_ptr increments with natural wrap.
    - Go to IDLE.
- **Parameter and input timing:**
  - `mode` and `delay_len` changes take effect at the next IDLE capture and never mid-sample.
  - A pure-delay output for delay_len=N is the input from N samples earlier, or zero if that sample predates the clear.

## Timing
- **Reset values:**
  - `read`=0, `write`=0, `writedata_*`=0, `busy`=1.
  - wr_ptr=0, clr_ptr=0, state CLEAR.
- **Reset mid-operation:**
  - Any captured sample is discarded and the clear restarts.
  - No `write` is issued for the discarded sample.
- **Clear duration:** `busy` falls 2^DEPTH_LOG2 cycles after reset deasserts. `read` stays 0 throughout CLEAR.
- **Latency:** From the `read` cycle (T) to the earliest `write` is T+3, with the state sequence IDLE(T), RD_MEM, COMPUTE, WAIT_WR(T+3).
- **Back-pressure:** WAIT_WR holds indefinitely while `write_ready`=0. `writedata_*` stays stable and `read` stays 0.
- **Throughput:** Maximum is one pair per 4 cycles, far above the codec sample rate.
- **Handshake rules:**
  - `read` and `write` are never high in the same cycle.
  - Each is high for at most one cycle per sample.
- **RAM write-read collision:** With delay_len=0, rd_addr=wr_ptr. This reads the oldest entry, which is written only later in WAIT_WR, so there is no read-during-write hazard.

## Test plan
The bench uses `DEPTH_LOG2`=4 and `GAIN_SHIFT`=1.
- **Reset/clear:** Pulse `reset` for 2 cycles with `read_ready`=1 → `busy`=1 for exactly 16 cycles after release, `read`=0 throughout, then `read`=1 in the first IDLE cycle.
- **Bypass and latency:** mode 00, input L=0x123456, R=0xFEDCBA, `write_ready`=1 → `write` exactly 3 cycles after `read`, with writedata equal to the input.
- **Feed-forward echo:** mode 01, delay_len=2, inputs 0x100000, 0, 0 on both channels → outputs 0x100000, 0, 0x080000.
- **Feedback and saturation:**
  - Mode 10, delay_len=1, input 0x100000 followed by zeros → outputs 0x100000, 0x080000, 0x040000, 0x020000.
  - Then input 0x7FFFF0 with delayed 0x7FFFF0 stored → output 0x7FFFFF.
  - Negative input 0x800010 under the same conditions → output 0x800000.
- **Pure delay and wrap:** mode 11, delay_len=0, feed 20 pairs of value k → outputs 0 for k<16, then k−16; wr_ptr wraps cleanly at 15→0.
- **Back-pressure and reset mid-sample:**
  - Hold `write_ready`=0 for 10 cycles in WAIT_WR → writedata stable, no `read`.
  - Assert `reset` in that state → no `write` is issued and the clear restarts with `busy`=1.
